// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, FSM state codes,
// and the field encodings for aluop, alusrcb and pcsrc.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Codes 14 and 15 are unused; they decode like S_IDLE and recover to S_FETCH.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTYPE  = 4'd7,
    S_ALUWB  = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BEQ    = 4'd11,
    S_JUMP   = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, control strobes out.
interface mips_multicycle_control_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pcwrite;
  logic                pcwritecond;
  logic                iord;
  logic                memread;
  logic                memwrite;
  logic                irwrite;
  logic                memtoreg;
  logic                regdst;
  logic                regwrite;
  logic                alusrca;
  logic [1:0]          alusrcb;
  logic [1:0]          pcsrc;
  logic [ALUOP_W-1:0]  aluop;
  logic                illegal;
  logic [3:0]          state;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, pcsrc, aluop, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, pcsrc, aluop, illegal, state
  );
endinterface

// File: rtl/mips_multicycle_control_outdec.sv
// Moore output decoder: control strobes from the current state; only the fetch-cycle
// PC/IR loads look at mem_ready, and the I-type ALU op at the latched opcode.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  state_t              i_state,
  input  logic                i_mem_ready,
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic                o_pcwrite,
  output logic                o_pcwritecond,
  output logic                o_iord,
  output logic                o_memread,
  output logic                o_memwrite,
  output logic                o_irwrite,
  output logic                o_memtoreg,
  output logic                o_regdst,
  output logic                o_regwrite,
  output logic                o_alusrca,
  output logic [1:0]          o_alusrcb,
  output logic [1:0]          o_pcsrc,
  output logic [ALUOP_W-1:0]  o_aluop,
  output logic                o_illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    o_pcwrite     = 1'b0;
    o_pcwritecond = 1'b0;
    o_iord        = 1'b0;
    o_memread     = 1'b0;
    o_memwrite    = 1'b0;
    o_irwrite     = 1'b0;
    o_memtoreg    = 1'b0;
    o_regdst      = 1'b0;
    o_regwrite    = 1'b0;
    o_alusrca     = 1'b0;
    o_alusrcb     = SRCB_RT;
    o_pcsrc       = PCSRC_ALU;
    o_aluop       = ALUOP_W'(ALUOP_ADD);
    o_illegal     = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_memread = 1'b1;
        o_alusrcb = SRCB_FOUR;
        o_irwrite = i_mem_ready;
        o_pcwrite = i_mem_ready;
      end
      S_DECODE: o_alusrcb = SRCB_IMM_SH2;
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        o_iord    = 1'b1;
        o_memread = 1'b1;
      end
      S_MEMWB: begin
        o_regwrite = 1'b1;
        o_memtoreg = 1'b1;
      end
      S_MEMWR: begin
        o_iord     = 1'b1;
        o_memwrite = 1'b1;
      end
      S_RTYPE: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_W'(ALUOP_FUNCT);
      end
      S_ALUWB: begin
        o_regwrite = 1'b1;
        o_regdst   = 1'b1;
      end
      S_IEXEC: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
        if (i_opcode == OPCODE_W'(OP_ORI))       o_aluop = ALUOP_W'(ALUOP_OR);
        else if (i_opcode == OPCODE_W'(OP_SLTI)) o_aluop = ALUOP_W'(ALUOP_SLT);
      end
      S_IWB: o_regwrite = 1'b1;
      S_BEQ: begin
        o_alusrca     = 1'b1;
        o_aluop       = ALUOP_W'(ALUOP_SUB);
        o_pcwritecond = 1'b1;
        o_pcsrc       = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_pcwrite = 1'b1;
        o_pcsrc   = PCSRC_JUMP;
      end
      S_TRAP: o_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: state register, decode-time opcode latch and
// next-state sequencing; control outputs come from mips_ctrl_outdec.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int ALUOP_W   = 3,
  parameter bit TRAP_HALT = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mips_multicycle_control_if.master bus
);

  state_t              r_state;
  state_t              w_next;
  logic [OPCODE_W-1:0] r_opcode;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= bus.opcode;
    end
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OPCODE_W'(OP_RTYPE):                                         w_next = S_RTYPE;
          OPCODE_W'(OP_LW), OPCODE_W'(OP_SW):                          w_next = S_MEMADR;
          OPCODE_W'(OP_BEQ):                                           w_next = S_BEQ;
          OPCODE_W'(OP_ADDI), OPCODE_W'(OP_ORI), OPCODE_W'(OP_SLTI):   w_next = S_IEXEC;
          OPCODE_W'(OP_J):                                             w_next = S_JUMP;
          default:                                                     w_next = S_TRAP;
        endcase
      end
      // Later states consult the latched opcode so a changing IR bus cannot redirect them.
      S_MEMADR: w_next = (r_opcode == OPCODE_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPE:  w_next = S_ALUWB;
      S_IEXEC:  w_next = S_IWB;
      S_TRAP:   w_next = TRAP_HALT ? S_TRAP : S_FETCH;
      default:  w_next = S_FETCH;
    endcase
  end

  assign bus.state = r_state;

  mips_ctrl_outdec #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_outdec (
    .i_state       (r_state),
    .i_mem_ready   (bus.mem_ready),
    .i_opcode      (r_opcode),
    .o_pcwrite     (bus.pcwrite),
    .o_pcwritecond (bus.pcwritecond),
    .o_iord        (bus.iord),
    .o_memread     (bus.memread),
    .o_memwrite    (bus.memwrite),
    .o_irwrite     (bus.irwrite),
    .o_memtoreg    (bus.memtoreg),
    .o_regdst      (bus.regdst),
    .o_regwrite    (bus.regwrite),
    .o_alusrca     (bus.alusrca),
    .o_alusrcb     (bus.alusrcb),
    .o_pcsrc       (bus.pcsrc),
    .o_aluop       (bus.aluop),
    .o_illegal     (bus.illegal)
  );

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class cycle by
// cycle, exercises stalls, mid-instruction reset and both trap modes.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst2_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   pc_cnt   = 0;
  int   cyc_cnt  = 0;
  int   pc0, c0;

  mips_multicycle_control_if bus ();
  mips_multicycle_control_if bus2 ();

  mips_multicycle_control #(.TRAP_HALT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mips_multicycle_control #(.TRAP_HALT(1'b0)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  assign bus2.opcode    = 6'b111111;
  assign bus2.mem_ready = 1'b1;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants plus pulse/cycle counters used by the stall test.
  always @(negedge clk) begin
    pc_cnt  += int'(bus.pcwrite);
    cyc_cnt += 1;
    check("inv_rd_wr",  {31'd0, bus.memread & bus.memwrite}, 32'd0);
    check("inv_rw_wr",  {31'd0, bus.regwrite & bus.memwrite}, 32'd0);
    check("inv_irwrite", {31'd0, bus.irwrite & !((bus.state == 4'(S_FETCH)) && bus.mem_ready)}, 32'd0);
  end

  initial begin
    bus.mem_ready = 1'b1;
    bus.opcode    = 6'b000000;
    #1;
    check("rst_outputs", {15'd0, bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
          bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb,
          bus.pcsrc, bus.aluop}, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    check("rst_state", {28'd0, bus.state}, 32'(S_IDLE));
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rel_idle", {28'd0, bus.state}, 32'(S_IDLE));
    tick();

    // R-type
    check("r_fetch_st", {28'd0, bus.state}, 32'(S_FETCH));
    check("r_fetch_pcw", {31'd0, bus.pcwrite}, 32'd1);
    check("r_fetch_irw", {31'd0, bus.irwrite}, 32'd1);
    check("r_fetch_mrd", {31'd0, bus.memread}, 32'd1);
    check("r_fetch_iord", {31'd0, bus.iord}, 32'd0);
    check("r_fetch_srcb", {30'd0, bus.alusrcb}, 32'd1);
    check("r_fetch_aluop", {29'd0, bus.aluop}, 32'd0);
    tick();
    check("r_dec_st", {28'd0, bus.state}, 32'(S_DECODE));
    check("r_dec_srcb", {30'd0, bus.alusrcb}, 32'd3);
    check("r_dec_pcw", {31'd0, bus.pcwrite}, 32'd0);
    check("r_dec_regw", {31'd0, bus.regwrite}, 32'd0);
    tick();
    check("r_ex_st", {28'd0, bus.state}, 32'(S_RTYPE));
    check("r_ex_srca", {31'd0, bus.alusrca}, 32'd1);
    check("r_ex_srcb", {30'd0, bus.alusrcb}, 32'd0);
    check("r_ex_aluop", {29'd0, bus.aluop}, 32'd2);
    check("r_ex_regw", {31'd0, bus.regwrite}, 32'd0);
    tick();
    check("r_wb_st", {28'd0, bus.state}, 32'(S_ALUWB));
    check("r_wb_regw", {31'd0, bus.regwrite}, 32'd1);
    check("r_wb_regdst", {31'd0, bus.regdst}, 32'd1);
    check("r_wb_m2r", {31'd0, bus.memtoreg}, 32'd0);
    tick();
    check("r_done_st", {28'd0, bus.state}, 32'(S_FETCH));
    check("r_done_regw", {31'd0, bus.regwrite}, 32'd0);

    // lw with 3 stalled fetch cycles and 2 stalled read cycles
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'b100011;
    pc0 = pc_cnt;
    c0  = cyc_cnt;
    #1;
    check("lw_stall_st", {28'd0, bus.state}, 32'(S_FETCH));
    check("lw_stall_pcw", {31'd0, bus.pcwrite}, 32'd0);
    check("lw_stall_irw", {31'd0, bus.irwrite}, 32'd0);
    check("lw_stall_mrd", {31'd0, bus.memread}, 32'd1);
    tick();
    check("lw_stall2_st", {28'd0, bus.state}, 32'(S_FETCH));
    tick();
    check("lw_stall3_pcw", {31'd0, bus.pcwrite}, 32'd0);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    check("lw_fetch_pcw", {31'd0, bus.pcwrite}, 32'd1);
    check("lw_fetch_irw", {31'd0, bus.irwrite}, 32'd1);
    tick();
    check("lw_dec_st", {28'd0, bus.state}, 32'(S_DECODE));
    tick();
    check("lw_adr_st", {28'd0, bus.state}, 32'(S_MEMADR));
    check("lw_adr_srca", {31'd0, bus.alusrca}, 32'd1);
    check("lw_adr_srcb", {30'd0, bus.alusrcb}, 32'd2);
    check("lw_adr_aluop", {29'd0, bus.aluop}, 32'd0);
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check("lw_rd_st", {28'd0, bus.state}, 32'(S_MEMRD));
    check("lw_rd_iord", {31'd0, bus.iord}, 32'd1);
    check("lw_rd_mrd", {31'd0, bus.memread}, 32'd1);
    tick();
    check("lw_rd2_st", {28'd0, bus.state}, 32'(S_MEMRD));
    tick();
    bus.mem_ready = 1'b1;
    #1;
    check("lw_rd3_st", {28'd0, bus.state}, 32'(S_MEMRD));
    tick();
    check("lw_wb_st", {28'd0, bus.state}, 32'(S_MEMWB));
    check("lw_wb_regw", {31'd0, bus.regwrite}, 32'd1);
    check("lw_wb_m2r", {31'd0, bus.memtoreg}, 32'd1);
    check("lw_wb_regdst", {31'd0, bus.regdst}, 32'd0);
    tick();
    check("lw_done_st", {28'd0, bus.state}, 32'(S_FETCH));
    check("lw_pc_pulses", 32'(pc_cnt - pc0), 32'd1);
    check("lw_cycles", 32'(cyc_cnt - c0), 32'd10);

    // sw
    bus.opcode = 6'b101011;
    #1;
    tick();
    tick();
    check("sw_adr_st", {28'd0, bus.state}, 32'(S_MEMADR));
    tick();
    check("sw_wr_st", {28'd0, bus.state}, 32'(S_MEMWR));
    check("sw_wr_mwr", {31'd0, bus.memwrite}, 32'd1);
    check("sw_wr_iord", {31'd0, bus.iord}, 32'd1);
    check("sw_wr_mrd", {31'd0, bus.memread}, 32'd0);
    tick();
    check("sw_done_st", {28'd0, bus.state}, 32'(S_FETCH));
    check("sw_done_mwr", {31'd0, bus.memwrite}, 32'd0);

    // beq
    bus.opcode = 6'b000100;
    #1;
    tick();
    tick();
    check("beq_st", {28'd0, bus.state}, 32'(S_BEQ));
    check("beq_pcwc", {31'd0, bus.pcwritecond}, 32'd1);
    check("beq_aluop", {29'd0, bus.aluop}, 32'd1);
    check("beq_pcsrc", {30'd0, bus.pcsrc}, 32'd1);
    check("beq_srca", {31'd0, bus.alusrca}, 32'd1);
    check("beq_srcb", {30'd0, bus.alusrcb}, 32'd0);
    tick();
    check("beq_done_st", {28'd0, bus.state}, 32'(S_FETCH));
    check("beq_done_pcwc", {31'd0, bus.pcwritecond}, 32'd0);

    // j
    bus.opcode = 6'b000010;
    #1;
    tick();
    tick();
    check("j_st", {28'd0, bus.state}, 32'(S_JUMP));
    check("j_pcw", {31'd0, bus.pcwrite}, 32'd1);
    check("j_pcsrc", {30'd0, bus.pcsrc}, 32'd2);
    tick();
    check("j_done_st", {28'd0, bus.state}, 32'(S_FETCH));

    // ori, with the opcode bus changed after decode to prove the latch holds
    bus.opcode = 6'b001101;
    #1;
    tick();
    tick();
    bus.opcode = 6'b100011;
    #1;
    check("ori_st", {28'd0, bus.state}, 32'(S_IEXEC));
    check("ori_aluop", {29'd0, bus.aluop}, 32'd3);
    check("ori_srcb", {30'd0, bus.alusrcb}, 32'd2);
    tick();
    check("ori_wb_st", {28'd0, bus.state}, 32'(S_IWB));
    check("ori_wb_regw", {31'd0, bus.regwrite}, 32'd1);
    check("ori_wb_regdst", {31'd0, bus.regdst}, 32'd0);
    check("ori_wb_m2r", {31'd0, bus.memtoreg}, 32'd0);
    tick();

    // slti
    bus.opcode = 6'b001010;
    #1;
    tick();
    tick();
    check("slti_aluop", {29'd0, bus.aluop}, 32'd4);
    tick();
    tick();
    check("slti_done_st", {28'd0, bus.state}, 32'(S_FETCH));

    // reset in the middle of a stalled load
    bus.opcode = 6'b100011;
    #1;
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check("rmid_mrd", {31'd0, bus.memread}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmid_outputs", {15'd0, bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
          bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca, bus.alusrcb,
          bus.pcsrc, bus.aluop}, 32'd0);
    check("rmid_state", {28'd0, bus.state}, 32'(S_IDLE));
    tick();
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check("rmid_idle", {28'd0, bus.state}, 32'(S_IDLE));
    tick();
    check("rmid_fetch", {28'd0, bus.state}, 32'(S_FETCH));

    // illegal opcode, halting trap
    bus.opcode = 6'b111111;
    #1;
    tick();
    tick();
    check("trap_st", {28'd0, bus.state}, 32'(S_TRAP));
    check("trap_ill", {31'd0, bus.illegal}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("trap_hold_ill", {31'd0, bus.illegal}, 32'd1);
      check("trap_hold_we", {27'd0, bus.pcwrite, bus.pcwritecond, bus.memwrite, bus.regwrite,
            bus.irwrite}, 32'd0);
    end
    check("trap_hold_st", {28'd0, bus.state}, 32'(S_TRAP));

    // illegal opcode, non-halting trap on the second instance
    rst2_n = 1'b1;
    #1;
    check("trap0_idle", {28'd0, bus2.state}, 32'(S_IDLE));
    tick();
    tick();
    check("trap0_dec", {28'd0, bus2.state}, 32'(S_DECODE));
    tick();
    check("trap0_st", {28'd0, bus2.state}, 32'(S_TRAP));
    check("trap0_ill", {31'd0, bus2.illegal}, 32'd1);
    tick();
    check("trap0_back_st", {28'd0, bus2.state}, 32'(S_FETCH));
    check("trap0_back_ill", {31'd0, bus2.illegal}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
